// File: rtl/cpu_defs.sv
// Shared CPU definitions: address translation result, exception record,
// exception codes and the memory request stage state encoding.
package cpu_defs;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_MOD  = 5'h01;
  localparam logic [4:0] EXCCODE_TLBL = 5'h02;
  localparam logic [4:0] EXCCODE_TLBS = 5'h03;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;

  typedef struct packed {
    logic [31:0] phy_addr;
    logic [31:0] virt_addr;
    logic        uncached;
    logic        miss;
    logic        invalid;
    logic        dirty;
    logic        illegal;
  } mmu_result_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
    logic        bd;
  } exception_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_req_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Byte-enable generation and misalignment detection for byte/half/word
// accesses from the access size and the low two address bits.
module mem_align_check (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misalign
);

  always_comb begin
    be       = 4'b1111;
    misalign = 1'b0;
    case (size)
      2'd0: be = 4'b0001 << addr_lo;
      2'd1: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_req_stage.sv
// Memory request stage: turns one load/store into a bus request and returns
// the result downstream. Define CPU_MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_req_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_op,
  input  logic        store_op,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  mmu_result_t mmu_res,
  input  exception_t  tlb_ex,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output exception_t  out_ex
);

`ifdef CPU_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  mem_req_state_t state;
  logic           kill;
  logic [3:0]     be;
  logic           misalign;
  logic           addr_err;
  logic           is_mem;
  logic           accept;
  exception_t     ex_next;
  logic           unused_bits;

  mem_align_check u_align (
    .size     (size),
    .addr_lo  (mmu_res.virt_addr[1:0]),
    .be       (be),
    .misalign (misalign)
  );

  assign addr_err = ALIGN_CHECK && misalign;
  assign in_ready = (state == MEM_IDLE);
  assign is_mem   = load_op | store_op;
  assign accept   = in_valid & in_ready & ~flush;

  assign unused_bits = ^{mmu_res.phy_addr[1:0], mmu_res.miss, mmu_res.invalid,
                         mmu_res.dirty, tlb_ex.badvaddr, tlb_ex.bd};

  // Exception priority: alignment, then illegal segment, then TLB.
  always_comb begin
    ex_next = '0;
    if (addr_err || mmu_res.illegal) begin
      ex_next.ex      = 1'b1;
      ex_next.exccode = store_op ? EXCCODE_ADES : EXCCODE_ADEL;
    end else if (tlb_ex.ex) begin
      ex_next.ex      = 1'b1;
      ex_next.exccode = tlb_ex.exccode;
    end
    if (ex_next.ex) ex_next.badvaddr = mmu_res.virt_addr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= MEM_IDLE;
      kill         <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      bus_uncached <= 1'b0;
      out_valid    <= 1'b0;
      out_rdata    <= '0;
      out_ex       <= '0;
    end else begin
      case (state)
        MEM_IDLE: if (accept) begin
          out_rdata <= '0;
          out_ex    <= '0;
          if (!is_mem) begin
            out_valid <= 1'b1;
            state     <= MEM_DONE;
          end else if (ex_next.ex) begin
            out_ex    <= ex_next;
            out_valid <= 1'b1;
            state     <= MEM_DONE;
          end else begin
            bus_req      <= 1'b1;
            bus_we       <= store_op;
            bus_addr     <= {mmu_res.phy_addr[31:2], 2'b00};
            bus_be       <= be;
            bus_wdata    <= wdata;
            bus_uncached <= mmu_res.uncached;
            state        <= MEM_REQ;
          end
        end
        MEM_REQ: if (bus_addr_ok) begin
          bus_req <= 1'b0;
          if (bus_data_ok) begin
            if (flush) begin
              state <= MEM_IDLE;
            end else begin
              out_rdata <= bus_rdata;
              out_valid <= 1'b1;
              state     <= MEM_DONE;
            end
          end else begin
            // Once the address is taken the response must still be absorbed.
            kill  <= flush;
            state <= MEM_WAIT;
          end
        end else if (flush) begin
          bus_req <= 1'b0;
          state   <= MEM_IDLE;
        end
        MEM_WAIT: if (bus_data_ok) begin
          kill <= 1'b0;
          if (kill || flush) begin
            state <= MEM_IDLE;
          end else begin
            out_rdata <= bus_rdata;
            out_valid <= 1'b1;
            state     <= MEM_DONE;
          end
        end else if (flush) begin
          kill <= 1'b1;
        end
        MEM_DONE: if (flush || out_ready) begin
          out_valid <= 1'b0;
          state     <= MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_stage.sv
// Scoreboard bench for mem_req_stage: directed scenarios plus randomized
// accesses against a behavioural model of exceptions, byte enables and bus data.
`timescale 1ns/1ps
module tb_mem_req_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, load_op, store_op, flush;
  logic [1:0]  size;
  logic [31:0] wdata;
  mmu_result_t mmu_res;
  exception_t  tlb_ex;
  logic        bus_req, bus_we, bus_uncached, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  exception_t  out_ex;

  mem_req_stage dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .load_op(load_op), .store_op(store_op), .size(size), .wdata(wdata),
    .mmu_res(mmu_res), .tlb_ex(tlb_ex), .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_uncached(bus_uncached),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_ex(out_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        unc;
    int          stall;
    int          lat;
    logic [31:0] rdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    exception_t  ex;
  } out_exp_t;

  bus_exp_t bus_q[$];
  out_exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;
  bit inject_dok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exception_t ref_ex(input bit ld, input bit st, input logic [1:0] sz,
                                        input logic [31:0] va, input bit ill, input exception_t tlb);
    exception_t e;
    bit mis;
    e = '0;
    mis = 1'b0;
    if (!(ld || st)) return e;
`ifdef CPU_MEM_ALIGN_CHECK_EN
    mis = (sz == 2'd1 && va[0]) || (sz == 2'd2 && va[1:0] != 2'b00);
`endif
    if (mis || ill) begin
      e.ex = 1'b1;
      e.exccode = st ? EXCCODE_ADES : EXCCODE_ADEL;
    end else if (tlb.ex) begin
      e.ex = 1'b1;
      e.exccode = tlb.exccode;
    end
    if (e.ex) e.badvaddr = va;
    return e;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] va);
    case (sz)
      2'd0:    return 4'(1 << va[1:0]);
      2'd1:    return va[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input logic [31:0] va,
                       input logic [31:0] wd, input bit unc, input bit ill, input exception_t tlb,
                       input int stall, input int lat, input logic [31:0] rd, input bit expect_out);
    exception_t e;
    bus_exp_t   b;
    out_exp_t   o;
    int guard;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    e = ref_ex(ld, st, sz, va, ill, tlb);
    in_valid = 1'b1; load_op = ld; store_op = st; size = sz; wdata = wd;
    mmu_res = '0;
    mmu_res.phy_addr  = va & 32'h1FFF_FFFF;
    mmu_res.virt_addr = va;
    mmu_res.uncached  = unc;
    mmu_res.dirty     = !(tlb.ex && tlb.exccode == EXCCODE_MOD);
    mmu_res.illegal   = ill;
    tlb_ex = tlb;
    o.ex = e;
    o.rdata = 32'h0;
    if ((ld || st) && !e.ex) begin
      b.addr = (va & 32'h1FFF_FFFF) & 32'hFFFF_FFFC;
      b.be = ref_be(sz, va); b.we = st; b.wdata = wd; b.unc = unc;
      b.stall = stall; b.lat = lat; b.rdata = rd;
      bus_q.push_back(b);
      o.rdata = rd;
    end
    if (expect_out) exp_q.push_back(o);
    @(posedge clk); #1;
    in_valid = 1'b0; load_op = 1'b0; store_op = 1'b0;
    mmu_res = mem_junk();
    tlb_ex = '0;
  endtask

  function automatic mmu_result_t mem_junk();
    mmu_result_t m;
    m = '0;
    m.phy_addr = $urandom;
    m.virt_addr = $urandom;
    return m;
  endfunction

  task automatic wait_done(output int lat, output int nreq);
    lat = 0;
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus_req) nreq++;
      if (out_valid) break;
    end
    @(posedge clk); #1;
  endtask

  // Bus responder and request checker share one process so sampling order is fixed.
  initial begin
    bit hs_a, hs_d, a_started, pend_d;
    int a_cnt, d_cnt, cur_lat;
    logic [31:0] cur_rd;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    a_started = 1'b0; pend_d = 1'b0; a_cnt = 0; d_cnt = 0; cur_lat = 1; cur_rd = 32'h0;
    forever begin
      @(negedge clk);
      hs_a = bus_req && bus_addr_ok;
      hs_d = bus_data_ok;
      if (bus_req) begin
        if (bus_q.size() == 0) begin
          chk("bus_req_unexpected", 64'(bus_req), 64'd0);
        end else begin
          chk("bus_addr", 64'(bus_addr), 64'(bus_q[0].addr));
          chk("bus_be", 64'(bus_be), 64'(bus_q[0].be));
          chk("bus_we", 64'(bus_we), 64'(bus_q[0].we));
          if (bus_q[0].we) chk("bus_wdata", 64'(bus_wdata), 64'(bus_q[0].wdata));
          chk("bus_uncached", 64'(bus_uncached), 64'(bus_q[0].unc));
          if (hs_a) void'(bus_q.pop_front());
        end
      end
      @(posedge clk); #2;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata = $urandom;
      if (hs_d) pend_d = 1'b0;
      else if (hs_a) begin pend_d = 1'b1; d_cnt = cur_lat - 1; end
      if (hs_a) a_started = 1'b0;
      if (!resetn) begin pend_d = 1'b0; a_started = 1'b0; end
      if (pend_d) begin
        if (d_cnt <= 0) begin bus_data_ok = 1'b1; bus_rdata = cur_rd; end
        else d_cnt--;
      end
      if (inject_dok) begin
        bus_data_ok = 1'b1;
        bus_rdata = 32'h5A5A_5A5A;
        inject_dok = 1'b0;
      end
      if (bus_req && !pend_d) begin
        if (!a_started) begin
          a_started = 1'b1;
          a_cnt = (bus_q.size() != 0) ? bus_q[0].stall : 0;
          cur_lat = (bus_q.size() != 0) ? bus_q[0].lat : 1;
          cur_rd = (bus_q.size() != 0) ? bus_q[0].rdata : 32'h0;
        end
        if (a_cnt == 0) begin
          bus_addr_ok = 1'b1;
          if (cur_lat == 0) begin bus_data_ok = 1'b1; bus_rdata = cur_rd; end
        end else begin
          a_cnt--;
        end
      end else if (!bus_req) begin
        a_started = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    out_exp_t o;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 64'(out_valid), 64'd0);
        end else begin
          o = exp_q.pop_front();
          chk("out_rdata", 64'(out_rdata), 64'(o.rdata));
          chk("out_ex", 64'(out_ex), 64'(o.ex));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    exception_t tlb;
    int lat, nreq, nval, kind;
    bit ld, st;
    logic [1:0] sz;
    resetn = 1'b0; in_valid = 1'b0; load_op = 1'b0; store_op = 1'b0; size = 2'd0;
    wdata = 32'h0; mmu_res = '0; tlb_ex = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_rdata", 64'(out_rdata), 64'd0);
    chk("rst_out_ex", 64'(out_ex), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_be", 64'(bus_be), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Word load through unmapped segment, zero-wait bus.
    issue(1, 0, 2'd2, 32'h8000_1004, 32'h0, 0, 0, '0, 0, 1, 32'hDEAD_BEEF, 1);
    wait_done(lat, nreq);
    chk("word_load_latency", 64'(lat), 64'd3);
    chk("word_load_nreq", 64'(nreq), 64'd1);

    // Byte store with a two-cycle address stall.
    issue(0, 1, 2'd0, 32'h0040_0003, 32'hAB00_0000, 0, 0, '0, 2, 1, 32'h1234_5678, 1);
    wait_done(lat, nreq);
    chk("byte_store_req_cycles", 64'(nreq), 64'd3);
    chk("byte_store_latency", 64'(lat), 64'd5);

    // Store hitting a clean page: TLB modify exception, no bus traffic.
    tlb = '0; tlb.ex = 1'b1; tlb.exccode = EXCCODE_MOD;
    issue(0, 1, 2'd2, 32'h0000_2000, 32'h5555_AAAA, 0, 0, tlb, 0, 1, 32'h0, 1);
    wait_done(lat, nreq);
    chk("mod_latency", 64'(lat), 64'd1);
    chk("mod_nreq", 64'(nreq), 64'd0);

    issue(0, 0, 2'd0, 32'h0000_0000, 32'h0, 0, 0, '0, 0, 1, 32'h0, 1);
    wait_done(lat, nreq);
    chk("noop_latency", 64'(lat), 64'd1);

    // Misaligned half load.
    issue(1, 0, 2'd1, 32'h0000_1003, 32'h0, 0, 0, '0, 0, 1, 32'hCAFE_F00D, 1);
    wait_done(lat, nreq);
`ifdef CPU_MEM_ALIGN_CHECK_EN
    chk("half_misalign_nreq", 64'(nreq), 64'd0);
    chk("half_misalign_latency", 64'(lat), 64'd1);
`else
    chk("half_misalign_nreq", 64'(nreq), 64'd1);
    chk("half_misalign_latency", 64'(lat), 64'd3);
`endif

    issue(0, 1, 2'd2, 32'h0000_3000, 32'h0, 0, 1, '0, 0, 1, 32'h0, 1);
    wait_done(lat, nreq);
    chk("illegal_store_nreq", 64'(nreq), 64'd0);

    // Flush while waiting for data: response absorbed, nothing delivered.
    issue(1, 0, 2'd2, 32'h0000_4000, 32'h0, 0, 0, '0, 0, 5, 32'h7777_7777, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    chk("flush_wait_busy", 64'(in_ready), 64'd0);
    nval = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) nval++;
    end
    @(posedge clk); #1;
    chk("flush_wait_no_valid", 64'(nval), 64'd0);
    chk("flush_wait_idle", 64'(in_ready), 64'd1);
    issue(1, 0, 2'd2, 32'h0000_4008, 32'h0, 0, 0, '0, 0, 1, 32'h0BAD_CAFE, 1);
    wait_done(lat, nreq);
    chk("after_flush_latency", 64'(lat), 64'd3);

    // Flush before the address is taken.
    issue(1, 0, 2'd2, 32'h0000_5000, 32'h0, 0, 0, '0, 4, 1, 32'h0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req_bus_req", 64'(bus_req), 64'd0);
    chk("flush_req_idle", 64'(in_ready), 64'd1);
    void'(bus_q.pop_front());

    // Flush and in_valid together: nothing accepted.
    in_valid = 1'b1; load_op = 1'b1; size = 2'd2; mmu_res = '0; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; load_op = 1'b0; flush = 1'b0;
    chk("flush_accept_bus_req", 64'(bus_req), 64'd0);
    chk("flush_accept_idle", 64'(in_ready), 64'd1);

    // Flush while holding a result.
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    tlb = '0; tlb.ex = 1'b1; tlb.exccode = EXCCODE_TLBL;
    issue(1, 0, 2'd2, 32'h0000_6000, 32'h0, 0, 0, tlb, 0, 1, 32'h0, 0);
    chk("done_hold_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_idle", 64'(in_ready), 64'd1);
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of a request, then a stray response.
    issue(1, 0, 2'd2, 32'h0000_7000, 32'h0, 0, 0, '0, 5, 1, 32'h0, 0);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_bus_req", 64'(bus_req), 64'd0);
    chk("rst_mid_bus_addr", 64'(bus_addr), 64'd0);
    void'(bus_q.pop_front());
    @(posedge clk); #1;
    resetn = 1'b1;
    inject_dok = 1'b1;
    nval = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) nval++;
    end
    @(posedge clk); #1;
    chk("stray_dok_no_valid", 64'(nval), 64'd0);
    chk("stray_dok_idle", 64'(in_ready), 64'd1);
    issue(1, 0, 2'd0, 32'h0000_7001, 32'h0, 0, 0, '0, 0, 1, 32'h0000_3300, 1);
    wait_done(lat, nreq);
    chk("after_reset_latency", 64'(lat), 64'd3);

    // Randomized traffic with random bus timing and downstream backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      ld = (kind >= 1 && kind <= 4);
      st = (kind >= 5);
      sz = 2'($urandom_range(0, 2));
      tlb = '0;
      if ($urandom_range(0, 7) == 0) begin
        tlb.ex = 1'b1;
        tlb.exccode = st ? (($urandom_range(0, 1) != 0) ? EXCCODE_MOD : EXCCODE_TLBS) : EXCCODE_TLBL;
        tlb.badvaddr = $urandom;
      end
      issue(ld, st, sz, $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), tlb, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom, 1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_out_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_bus_queue", 64'(bus_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_req_stage.md
MEM_REQ_STAGE -- requirements
Module: mem_req_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 in_valid / in_ready  in / out  1 / 1  upstream handshake; an access is accepted when both are 1.
REQ-004 load_op, store_op  in  1 each  access kind; in_valid with neither set is a no-op.
REQ-005 size  in  2  access size: 0=byte, 1=half, 2=word.
REQ-006 wdata  in  32  store data, already lane-aligned.
REQ-007 mmu_res  in  mmu_result_t  data translation of the current address (phy_addr, virt_addr, uncached, miss, invalid, dirty, illegal).
REQ-008 tlb_ex  in  exception_t  data TLB exception for the current address.
REQ-009 flush  in  1  kill the in-flight access.
REQ-010 bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_uncached  out  1, 1, 32, 4, 32, 1  memory request.
REQ-011 bus_addr_ok  in  1  request accepted by memory.
REQ-012 bus_data_ok, bus_rdata  in  1, 32  response valid and load data.
REQ-013 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-014 out_rdata  out  32  load result.
REQ-015 out_ex  out  exception_t  exception attached to the result.

Function
REQ-016 States are IDLE, REQ, WAIT, DONE; in_ready is 1 only in IDLE.
REQ-017 IDLE, accepted load/store: compute the final exception from address check, then mmu_res.illegal (AdEL/AdES), then tlb_ex.ex. If an exception is present, latch it and go to DONE with no bus_req; otherwise latch phy_addr, byte enables, wdata and uncached, and go to REQ.
REQ-018 Accepted no-op: go to DONE with out_ex.ex=0 and out_rdata=0.
REQ-019 REQ: hold bus_req=1 with all bus_* outputs stable. On bus_addr_ok go to WAIT; if bus_data_ok arrives in the same cycle, go directly to DONE.
REQ-020 WAIT: on bus_data_ok, latch bus_rdata into out_rdata and go to DONE. Stores also wait for bus_data_ok.
REQ-021 DONE: out_valid=1. On out_ready go to IDLE, giving a minimum of one bubble per access.
REQ-022 Byte enables: byte gives 1<<a[1:0]; half gives 0011 or 1100 per a[1]; word gives 1111; bus_addr is phy_addr with bits [1:0] forced to 0.
REQ-023 Minimum latency from acceptance to out_valid: 3 cycles with a zero-wait bus, 1 cycle for exceptions and no-ops.
REQ-024 flush in IDLE, REQ (before addr_ok) or DONE: go to IDLE next cycle; drop bus_req the same cycle the state leaves REQ.
REQ-025 flush in WAIT, or in REQ together with addr_ok: set a kill flag and stay until bus_data_ok; discard the data and go to IDLE without out_valid.
REQ-026 flush and in_valid in the same cycle: flush wins and nothing is accepted.
REQ-027 out_ex.badvaddr equals mmu_res.virt_addr of the faulting access; out_ex.bd=0.

Reset
REQ-028 Asserting resetn low shall, asynchronously, set the state to IDLE, clear the kill flag, drive bus_req=0 and out_valid=0, and zero out_rdata, out_ex and all latched bus fields.
REQ-029 Reset during REQ or WAIT shall abandon the access; a later stray bus_data_ok in IDLE shall be ignored.

Configuration
REQ-030 Macro CPU_MEM_ALIGN_CHECK_EN, when defined, shall raise AdEL (loads) or AdES (stores) for a misaligned half or word access, with no bus request issued.
REQ-031 Without CPU_MEM_ALIGN_CHECK_EN, no alignment exception shall be raised; bus_addr still has bits [1:0]=0 and byte enables follow REQ-022.

Structure
REQ-032 The state enum mem_req_state_t and the EXCCODE_ADEL/ADES constants shall live in the shared cpu_defs package; mmu_result_t and exception_t shall be reused from it.
REQ-033 One combinational sub-module, mem_align_check, shall produce the byte enables and the misalign flag from size and addr[1:0].

Verification
REQ-034 Word load at va 0x80001004 (unmapped), bus zero-wait, rdata 0xDEADBEEF: bus_addr=0x00001004, be=1111, out_rdata=0xDEADBEEF, out_ex.ex=0.
REQ-035 Byte store at va 0x00400003, dirty=1, 2-cycle addr_ok stall: bus_req and bus fields held for 3 cycles, be=1000, we=1.
REQ-036 Store with miss=0, valid=1, dirty=0 (tlb_ex MOD): out_ex.exccode=MOD, no bus_req, out_valid 1 cycle after acceptance.
REQ-037 Half load at va 0x1003 with CPU_MEM_ALIGN_CHECK_EN: AdEL, badvaddr=0x1003; without the macro: bus access with be=1100.
REQ-038 flush in WAIT, data_ok 4 cycles later: out_valid stays 0, state returns to IDLE, the next load completes normally.
REQ-039 resetn low mid-REQ: bus_req=0 immediately; a stray data_ok after release produces no out_valid.
